// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit for the E stage: owns HI/LO, produces Start/Busy for the
// D-stage stall logic, and commits each result a fixed number of cycles after launch.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDOp,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        Req,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] E_MDOut
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic          pend_dz_q, pend_dz_d;

  logic          is_arith;
  logic [63:0]   a_sx, b_sx, prod_s, prod_u;
  logic [31:0]   a_mag, b_mag, dvs_s, dvs_u;
  logic [31:0]   uq_s, ur_s, q_s, r_s, q_u, r_u;

  assign is_arith = (E_MDOp >= OP_MULT) && (E_MDOp <= OP_DIVU);
  assign Start    = is_arith && !busy_q && !Req;
  assign Busy     = busy_q;
  assign HI       = hi_q;
  assign LO       = lo_q;

  always_comb begin
    E_MDOut = 32'd0;
    if (E_MDOp == OP_MFHI)      E_MDOut = hi_q;
    else if (E_MDOp == OP_MFLO) E_MDOut = lo_q;
  end

  // Signed divide works on magnitudes so 0x80000000 / -1 needs no special case.
  always_comb begin
    a_sx   = {{32{E_A[31]}}, E_A};
    b_sx   = {{32{E_B[31]}}, E_B};
    prod_s = a_sx * b_sx;
    prod_u = {32'd0, E_A} * {32'd0, E_B};
    a_mag  = E_A[31] ? (32'd0 - E_A) : E_A;
    b_mag  = E_B[31] ? (32'd0 - E_B) : E_B;
    dvs_s  = (b_mag == 32'd0) ? 32'd1 : b_mag;
    dvs_u  = (E_B == 32'd0) ? 32'd1 : E_B;
    uq_s   = a_mag / dvs_s;
    ur_s   = a_mag % dvs_s;
    q_s    = (E_A[31] ^ E_B[31]) ? (32'd0 - uq_s) : uq_s;
    r_s    = E_A[31] ? (32'd0 - ur_s) : ur_s;
    q_u    = E_A / dvs_u;
    r_u    = E_A % dvs_u;
  end

  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_dz_d = pend_dz_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1) && !pend_dz_q) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end else if (Start) begin
      pend_dz_d = 1'b0;
      case (E_MDOp)
        OP_MULT: begin
          {pend_hi_d, pend_lo_d} = prod_s;
          cnt_d = CW'(MULT_CYCLES);
        end
        OP_MULTU: begin
          {pend_hi_d, pend_lo_d} = prod_u;
          cnt_d = CW'(MULT_CYCLES);
        end
        OP_DIV: begin
          pend_hi_d = r_s;
          pend_lo_d = q_s;
          pend_dz_d = (E_B == 32'd0);
          cnt_d     = CW'(DIV_CYCLES);
        end
        default: begin
          pend_hi_d = r_u;
          pend_lo_d = q_u;
          pend_dz_d = (E_B == 32'd0);
          cnt_d     = CW'(DIV_CYCLES);
        end
      endcase
    end else if (!Req) begin
      if (E_MDOp == OP_MTHI)      hi_d = E_A;
      else if (E_MDOp == OP_MTLO) lo_d = E_A;
    end
  end

  assign busy_d = (cnt_d != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_dz_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_dz_q <= pend_dz_d;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed plan cases plus random ops against a
// cycle-level arithmetic reference model; a negedge monitor does all comparisons.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  E_MDOp;
  logic [31:0] E_A, E_B;
  logic        Req;
  logic        Start, Busy;
  logic [31:0] HI, LO, E_MDOut;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .E_MDOp(E_MDOp), .E_A(E_A), .E_B(E_B), .Req(Req),
    .Start(Start), .Busy(Busy), .HI(HI), .LO(LO), .E_MDOut(E_MDOut)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] hi; logic [31:0] lo; int n; } exp_t;
  typedef struct { string name; logic [31:0] act; logic [31:0] exp; } dchk_t;

  exp_t        exp_q[$];
  bit          start_q[$];
  logic [31:0] rd_q[$];
  dchk_t       dq[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          mon_en  = 1'b0;

  // reference model state (owned by the stimulus process)
  logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
  bit          m_dz = 0;
  int          m_cnt = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: the only process that compares and counts
  dchk_t d;
  exp_t  e;
  int    run = 0;
  bit    prev_busy = 0;
  always @(negedge clk) begin
    while (dq.size() > 0) begin
      d = dq.pop_front();
      cmp(d.name, d.act, d.exp);
    end
    if (mon_en) begin
      if (E_MDOp >= 4'd1 && E_MDOp <= 4'd4) begin
        if (start_q.size() == 0) cmp("start_q_underflow", 32'd1, 32'd0);
        else cmp("start", {31'd0, Start}, {31'd0, start_q.pop_front()});
      end
      if (E_MDOp == 4'd5 || E_MDOp == 4'd6) begin
        if (rd_q.size() == 0) cmp("rd_q_underflow", 32'd1, 32'd0);
        else cmp("mdout", E_MDOut, rd_q.pop_front());
      end
      if (Busy) run++;
      else if (prev_busy) begin
        if (exp_q.size() == 0) cmp("unexpected_busy", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          cmp("commit_hi", HI, e.hi);
          cmp("commit_lo", LO, e.lo);
          cmp("busy_cycles", run, e.n);
        end
        run = 0;
      end
      prev_busy = Busy;
    end else begin
      prev_busy = 0;
      run = 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    dchk_t x;
    x.name = nm; x.act = act; x.exp = exp;
    dq.push_back(x);
  endtask

  // one E-stage cycle: drive, record expectations, advance model at the edge
  task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic r);
    bit arith, st;
    longint sa, sb, sq, sr;
    logic [63:0] p;
    exp_t x;
    E_MDOp = op; E_A = a; E_B = b; Req = r;
    arith = (op >= 4'd1 && op <= 4'd4);
    st = arith && (m_cnt == 0) && !r;
    if (arith) start_q.push_back(st);
    if (op == 4'd5) rd_q.push_back(m_hi);
    if (op == 4'd6) rd_q.push_back(m_lo);
    @(posedge clk);
    if (m_cnt != 0) begin
      m_cnt--;
      if (m_cnt == 0 && !m_dz) begin m_hi = p_hi; m_lo = p_lo; end
    end else if (st) begin
      m_dz = 0;
      case (op)
        4'd1: begin
          sa = longint'($signed(a)); sb = longint'($signed(b));
          p = 64'(sa * sb);
          p_hi = p[63:32]; p_lo = p[31:0]; m_cnt = 5;
        end
        4'd2: begin
          p = {32'd0, a} * {32'd0, b};
          p_hi = p[63:32]; p_lo = p[31:0]; m_cnt = 5;
        end
        4'd3: begin
          m_cnt = 10; m_dz = (b == 0);
          if (!m_dz) begin
            sa = longint'($signed(a)); sb = longint'($signed(b));
            sq = sa / sb; sr = sa % sb;
            p_lo = sq[31:0]; p_hi = sr[31:0];
          end
        end
        default: begin
          m_cnt = 10; m_dz = (b == 0);
          if (!m_dz) begin p_lo = a / b; p_hi = a % b; end
        end
      endcase
      x.hi = m_dz ? m_hi : p_hi;
      x.lo = m_dz ? m_lo : p_lo;
      x.n  = m_cnt;
      exp_q.push_back(x);
    end else if (!r && op == 4'd7) m_hi = a;
    else if (!r && op == 4'd8) m_lo = a;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'd0, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; E_MDOp = 0; E_A = 0; E_B = 0; Req = 0;
    #1 reset = 1'b0;
    #2;
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    #9 reset = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    step(4'd1, 32'hFFFFFFFD, 32'd5, 0); idle(5);
    chk("mult_hi", HI, 32'hFFFFFFFF); chk("mult_lo", LO, 32'hFFFFFFF1);
    step(4'd5, 0, 0, 0);
    step(4'd2, 32'hFFFFFFFF, 32'd2, 0); idle(5);
    chk("multu_hi", HI, 32'd1); chk("multu_lo", LO, 32'hFFFFFFFE);
    step(4'd4, 32'd7, 32'd2, 0); idle(10);
    chk("divu_hi", HI, 32'd1); chk("divu_lo", LO, 32'd3);
    step(4'd3, 32'hFFFFFFF9, 32'd2, 0); idle(10);
    chk("div_hi", HI, 32'hFFFFFFFF); chk("div_lo", LO, 32'hFFFFFFFD);
    step(4'd7, 32'h11, 0, 0); step(4'd8, 32'h22, 0, 0);
    step(4'd3, 32'd5, 32'd0, 0); idle(10);
    chk("dz_hi", HI, 32'h11); chk("dz_lo", LO, 32'h22);
    step(4'd3, 32'h80000000, 32'hFFFFFFFF, 0); idle(10);
    chk("ovf_hi", HI, 32'd0); chk("ovf_lo", LO, 32'h80000000);
    step(4'd7, 32'hAA, 0, 1);
    step(4'd1, 32'd3, 32'd4, 1); idle(2);
    chk("req_hi", HI, 32'd0); chk("req_lo", LO, 32'h80000000);
    step(4'd5, 0, 0, 0); step(4'd6, 0, 0, 0);
    step(4'd4, 32'd100, 32'd7, 0);
    repeat (3) step(4'd0, 0, 0, 1);
    idle(7);
    chk("reqmid_hi", HI, 32'd2); chk("reqmid_lo", LO, 32'd14);
    step(4'd1, 32'd6, 32'd7, 0);
    step(4'd7, 32'hDEAD, 0, 0); step(4'd3, 32'd9, 32'd3, 0); step(4'd6, 0, 0, 0);
    idle(2);
    chk("busyign_hi", HI, 32'd0); chk("busyign_lo", LO, 32'd42);
    step(4'd9, 32'h1234, 32'h1, 0); step(4'd5, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      a  = ($urandom_range(0, 3) == 0) ? 32'h80000000 - 32'($urandom_range(0, 2)) : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) - 32'd1 : $urandom;
      step(op, a, b, ($urandom_range(0, 7) == 0));
    end
    idle(11);
    chk("queues_drained", 32'(exp_q.size() + start_q.size() + rd_q.size()), 32'd0);

    // reset during the third Busy cycle clears state without a clock edge
    step(4'd7, 32'h55, 0, 0); step(4'd8, 32'h66, 0, 0);
    step(4'd1, 32'd3, 32'd3, 0); idle(2);
    mon_en = 1'b0;
    chk("pre_rst_busy", {31'd0, Busy}, 32'd1);
    exp_q.delete(); start_q.delete(); rd_q.delete();
    #2 reset = 1'b0;
    #1;
    chk("async_rst_busy", {31'd0, Busy}, 32'd0);
    chk("async_rst_hi", HI, 32'd0);
    chk("async_rst_lo", LO, 32'd0);
    #3 reset = 1'b1;
    repeat (3) @(negedge clk);
    #1 $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
